usb_tx: RTL and testbench



---
 rtl/usb_pkg.sv | 28 ++
 rtl/usb_sync_fifo.sv | 58 +++++
 rtl/usb_tx.sv | 123 ++++++++++++
 tb/tb_usb_tx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the FT245 USB FIFO interface: FSM state encoding,
// bus active levels and default write-cycle timing.
package usb_pkg;

  // Write-cycle FSM states (3-bit encoding)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  // FT245 active levels: WR latches on its falling edge, TXE# low means room
  localparam logic WR_ACTIVE    = 1'b1;
  localparam logic TXE_HAS_ROOM = 1'b0;

  // Default geometry and timing, in clk cycles
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_SETUP_CYC  = 2;
  localparam int DEF_STROBE_CYC = 4;
  localparam int DEF_HOLD_CYC   = 1;
  localparam int DEF_RECOV_CYC  = 4;

  // Down-counter load value for a phase lasting cyc cycles
  function automatic logic [7:0] cnt_load(input int cyc);
    return 8'(cyc - 1);
  endfunction

endpackage

// File: rtl/usb_sync_fifo.sv
// Small synchronous FIFO with combinational head. A byte written on one edge
// is visible at the head only after that edge, so it can be popped one edge
// later at the earliest. Shared by the transmit and receive paths.
module usb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage write; contents are don't-care until pushed
  // NOTE: the array has no reset -- level and pointers define validity, and a resettable array would cost a mux per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/usb_tx.sv
// FT245 write-side transmitter: buffers bytes from the core and runs paced
// write cycles (setup, WR strobe, hold, recovery) on the shared data bus.
// The parent owns the tristate: d = d_oe ? d_out : 'z.
module usb_tx
  import usb_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int RECOV_CYC  = DEF_RECOV_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   txe,
  input  logic                   rx_busy,
  output logic                   wr,
  output logic [7:0]             d_out,
  output logic                   d_oe,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  logic [2:0] state;
  logic [7:0] cnt;
  logic       txe_meta;
  logic       txe_s;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       start;

  // A new cycle starts only from IDLE; txe/rx_busy are not looked at elsewhere,
  // so a started byte always runs to completion.
  assign start    = (state == ST_IDLE) && !fifo_empty &&
                    (txe_s == TXE_HAS_ROOM) && !rx_busy;
  assign in_ready = rst_n && !fifo_full;
  assign busy     = (state != ST_IDLE);

  usb_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (start),
    .head  (fifo_head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Two-flop synchroniser for TXE#; resets to "device full"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txe_meta <= 1'b1;
      txe_s    <= 1'b1;
    end else begin
      txe_meta <= txe;
      txe_s    <= txe_meta;
    end
  end

  // Write-cycle sequencer: one shared down-counter times every phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      wr    <= ~WR_ACTIVE;
      d_oe  <= 1'b0;
      d_out <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            d_out <= fifo_head;
            d_oe  <= 1'b1;
            cnt   <= cnt_load(SETUP_CYC);
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == 8'd0) begin
            wr    <= WR_ACTIVE;
            cnt   <= cnt_load(STROBE_CYC);
            state <= ST_STROBE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt == 8'd0) begin
            wr    <= ~WR_ACTIVE;
            cnt   <= cnt_load(HOLD_CYC);
            state <= ST_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == 8'd0) begin
            d_oe  <= 1'b0;
            cnt   <= cnt_load(RECOV_CYC);
            state <= ST_RECOVER;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RECOVER: begin
          if (cnt == 8'd0) state <= ST_IDLE;
          else             cnt   <= cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx.sv
// Self-checking bench for usb_tx: scenario tasks plus a bus monitor that
// pops an expected-byte queue on every WR falling edge.
module tb_usb_tx;

  localparam int DEPTH  = 16;
  localparam int SETUP  = 2;
  localparam int STROBE = 4;
  localparam int HOLD   = 1;
  localparam int RECOV  = 4;
  localparam int OE_LEN = SETUP + STROBE + HOLD;
  localparam int PERIOD = 1 + SETUP + STROBE + HOLD + RECOV;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       txe;
  logic       rx_busy;
  logic       wr;
  logic [7:0] d_out;
  logic       d_oe;
  logic       busy;
  logic [4:0] level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_q[$];

  // monitor state
  logic prev_wr = 1'b0, prev_doe = 1'b0;
  int   wr_hi = 0, doe_hi = 0;
  int   wr_rises = 0, wr_falls = 0, doe_rises = 0;
  int   last_rise = 0;
  bit   have_rise = 1'b0;
  int   per_min = 1000000, per_max = 0;

  usb_tx #(
    .DEPTH      (DEPTH),
    .SETUP_CYC  (SETUP),
    .STROBE_CYC (STROBE),
    .HOLD_CYC   (HOLD),
    .RECOV_CYC  (RECOV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .txe      (txe),
    .rx_busy  (rx_busy),
    .wr       (wr),
    .d_out    (d_out),
    .d_oe     (d_oe),
    .busy     (busy),
    .level    (level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Bus monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wr = 1'b0; prev_doe = 1'b0; wr_hi = 0; doe_hi = 0; have_rise = 1'b0;
    end else begin
      if (wr && !prev_wr) begin
        wr_rises++;
        total++;
        if (d_oe !== 1'b1) begin bad++; $display("FAIL wr_rise_oe got=%b exp=1", d_oe); end
        if (have_rise) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
        have_rise = 1'b1;
      end
      if (!wr && prev_wr) begin
        wr_falls++;
        total++;
        if (wr_hi != STROBE) begin bad++; $display("FAIL wr_width got=%0d exp=%0d", wr_hi, STROBE); end
        total++;
        if (d_oe !== 1'b1) begin bad++; $display("FAIL hold_oe got=%b exp=1", d_oe); end
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL unexpected_write got=%02h exp=none", d_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (d_out !== e) begin bad++; $display("FAIL write_data got=%02h exp=%02h", d_out, e); end
        end
      end
      if (d_oe && !prev_doe) doe_rises++;
      if (!d_oe && prev_doe) begin
        total++;
        if (doe_hi != OE_LEN) begin bad++; $display("FAIL oe_width got=%0d exp=%0d", doe_hi, OE_LEN); end
      end
      wr_hi    = wr   ? wr_hi + 1  : 0;
      doe_hi   = d_oe ? doe_hi + 1 : 0;
      prev_wr  = wr;
      prev_doe = d_oe;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input int budget);
    bit done = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin done = 1'b1; exp_q.push_back(b); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (!done) begin bad++; $display("FAIL push_timeout byte=%02h got=not_accepted exp=accepted", b); end
  endtask

  task automatic wait_falls(input int n, input int budget);
    int i = 0;
    while (wr_falls < n && i < budget) begin tick(); i++; end
    total++;
    if (wr_falls < n) begin bad++; $display("FAIL wait_falls got=%0d exp=%0d", wr_falls, n); end
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while ((busy || level != 0) && i < budget) begin tick(); i++; end
    total++;
    if (busy || level != 0) begin bad++; $display("FAIL idle_timeout busy=%b level=%0d exp=0/0", busy, level); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; txe = 1'b1; rx_busy = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (wr !== 1'b0)       begin bad++; $display("FAIL rst_wr got=%b exp=0", wr); end
    total++; if (d_oe !== 1'b0)     begin bad++; $display("FAIL rst_oe got=%b exp=0", d_oe); end
    total++; if (d_out !== 8'h00)   begin bad++; $display("FAIL rst_dout got=%02h exp=00", d_out); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if (level !== 5'd0)    begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    int base = wr_falls;
    txe = 1'b0;
    repeat (3) tick();
    push_byte(8'hA5, 4);
    for (int j = 0; j <= 12; j++) begin
      logic e_oe, e_wr, e_busy;
      @(negedge clk);
      e_oe   = (j >= 1 && j <= 7);
      e_wr   = (j >= 3 && j <= 6);
      e_busy = (j >= 1 && j <= 11);
      total++; if (d_oe !== e_oe)   begin bad++; $display("FAIL single_oe t=%0d got=%b exp=%b", j, d_oe, e_oe); end
      total++; if (wr !== e_wr)     begin bad++; $display("FAIL single_wr t=%0d got=%b exp=%b", j, wr, e_wr); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL single_busy t=%0d got=%b exp=%b", j, busy, e_busy); end
      if (j == 1) begin
        total++; if (d_out !== 8'hA5) begin bad++; $display("FAIL single_dout got=%02h exp=a5", d_out); end
      end
    end
    total++; if (level !== 5'd0)        begin bad++; $display("FAIL single_level got=%0d exp=0", level); end
    total++; if (wr_falls != base + 1)  begin bad++; $display("FAIL single_count got=%0d exp=%0d", wr_falls - base, 1); end
  endtask

  task automatic test_burst();
    int  base;
    bit  acc = 1'b0;
    txe = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 16; i++) push_byte(8'(i), 3);
    in_data = 8'h10; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
      total++; if (level !== 5'd16)   begin bad++; $display("FAIL full_level got=%0d exp=16", level); end
      @(posedge clk); #1;
    end
    have_rise = 1'b0; per_min = 1000000; per_max = 0; base = wr_falls;
    txe = 1'b0;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin acc = 1'b1; exp_q.push_back(8'h10); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (!acc) begin bad++; $display("FAIL held_byte got=not_accepted exp=accepted"); end
    wait_falls(base + 17, 17 * PERIOD + 50);
    total++; if (per_min != PERIOD) begin bad++; $display("FAIL burst_period_min got=%0d exp=%0d", per_min, PERIOD); end
    total++; if (per_max != PERIOD) begin bad++; $display("FAIL burst_period_max got=%0d exp=%0d", per_max, PERIOD); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL burst_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_flow();
    int base  = wr_falls;
    int obase = doe_rises;
    int i = 0;
    txe = 1'b0;
    push_byte(8'h31, 3);
    push_byte(8'h32, 3);
    push_byte(8'h33, 3);
    while (!wr && i < 40) begin @(negedge clk); i++; end
    total++; if (!wr) begin bad++; $display("FAIL flow_first_wr got=0 exp=1"); end
    tick();
    txe = 1'b1;
    repeat (40) tick();
    total++; if (wr_falls != base + 1)    begin bad++; $display("FAIL flow_paused_writes got=%0d exp=1", wr_falls - base); end
    total++; if (doe_rises != obase + 1)  begin bad++; $display("FAIL flow_paused_oe got=%0d exp=1", doe_rises - obase); end
    total++; if (level !== 5'd2)          begin bad++; $display("FAIL flow_level got=%0d exp=2", level); end
    txe = 1'b0;
    wait_falls(base + 3, 3 * PERIOD + 20);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL flow_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_arb();
    int base  = wr_falls;
    int obase = doe_rises;
    rx_busy = 1'b1;
    push_byte(8'h41, 3);
    push_byte(8'h42, 3);
    repeat (10) tick();
    @(negedge clk);
    total++; if (level !== 5'd2)         begin bad++; $display("FAIL arb_level got=%0d exp=2", level); end
    total++; if (doe_rises != obase)     begin bad++; $display("FAIL arb_oe_rises got=%0d exp=0", doe_rises - obase); end
    total++; if (wr !== 1'b0 || d_oe !== 1'b0) begin bad++; $display("FAIL arb_bus got=%b%b exp=00", wr, d_oe); end
    @(posedge clk); #1;
    rx_busy = 1'b0;
    @(negedge clk);
    total++; if (d_oe !== 1'b0) begin bad++; $display("FAIL arb_early got=%b exp=0", d_oe); end
    @(negedge clk);
    total++; if (d_oe !== 1'b1) begin bad++; $display("FAIL arb_start got=%b exp=1", d_oe); end
    wait_falls(base + 2, 2 * PERIOD + 20);
  endtask

  task automatic test_back_to_back();
    int base = wr_falls;
    rx_busy = 1'b1;
    push_byte(8'h51, 3);
    rx_busy = 1'b0; in_data = 8'h52; in_valid = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || level !== 5'd1) begin bad++; $display("FAIL simul_pre got=%b/%0d exp=1/1", in_ready, level); end
    exp_q.push_back(8'h52);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (level !== 5'd1)   begin bad++; $display("FAIL simul_level got=%0d exp=1", level); end
    total++; if (d_oe !== 1'b1)    begin bad++; $display("FAIL simul_oe got=%b exp=1", d_oe); end
    total++; if (d_out !== 8'h51)  begin bad++; $display("FAIL simul_dout got=%02h exp=51", d_out); end
    wait_falls(base + 2, 2 * PERIOD + 20);
  endtask

  task automatic test_reset_mid();
    int i = 0;
    int base;
    txe = 1'b0;
    push_byte(8'h61, 3);
    push_byte(8'h62, 3);
    while (!wr && i < 40) begin @(negedge clk); i++; end
    total++; if (!wr) begin bad++; $display("FAIL rmid_wr got=0 exp=1"); end
    rst_n = 1'b0;
    #1;
    total++; if (wr !== 1'b0)       begin bad++; $display("FAIL rmid_wr_drop got=%b exp=0", wr); end
    total++; if (d_oe !== 1'b0)     begin bad++; $display("FAIL rmid_oe_drop got=%b exp=0", d_oe); end
    total++; if (level !== 5'd0)    begin bad++; $display("FAIL rmid_level got=%0d exp=0", level); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_in_ready got=%b exp=0", in_ready); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = wr_rises;
    repeat (40) tick();
    total++; if (wr_rises != base) begin bad++; $display("FAIL rmid_activity got=%0d exp=0", wr_rises - base); end
    total++; if (level !== 5'd0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_idle got=%0d/%b exp=0/0", level, busy); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    wait_idle(100);
    test_burst();
    wait_idle(100);
    test_flow();
    wait_idle(100);
    test_arb();
    wait_idle(100);
    test_back_to_back();
    wait_idle(100);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
